// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
// Shared definitions for the program-counter fetch stage:
//   - next-PC select encodings driven on pcSrc
//   - fetch-stage FSM states
//   - instruction step size and an alignment helper
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JALR   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] INSTR_STEP = 32'd4;

    // True when addr is a legal 32-bit instruction address.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC, presents it to instruction memory with a
// valid/ready handshake, selects the next PC and traps on misaligned
// control-flow targets. Also counts accepted fetches.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   stall      in   holds the PC (priority over everything except reset)
//   pcSrc      in   next-PC select (PC+4 / pcTarget / jalr / reserved=PC+4)
//   pcTarget   in   branch/jal target from the upstream target adder
//   aluResult  in   jalr target before bit-0 clear
//   imemReady  in   instruction memory accepts the current PC
//   PC         out  current program counter
//   pcPlus4    out  PC + 4, combinational, wraps mod 2^32
//   imemValid  out  PC is a valid fetch request (high only in RUN)
//   misaligned out  sticky trap flag
//   badAddr    out  offending target captured at trap
//   fetchCount out  number of accepted fetches, wraps at 2^COUNT_W
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [1:0]         pcSrc,
    input  logic [31:0]        pcTarget,
    input  logic [31:0]        aluResult,
    input  logic               imemReady,
    output logic [31:0]        PC,
    output logic [31:0]        pcPlus4,
    output logic               imemValid,
    output logic               misaligned,
    output logic [31:0]        badAddr,
    output logic [COUNT_W-1:0] fetchCount
);

    fetch_state_e state, state_next;
    logic [31:0]  next_pc;
    logic         advance;
    logic         target_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        pcPlus4    = PC + INSTR_STEP;
        imemValid  = (state == RUN);
        advance    = (state == RUN) && imemValid && imemReady && !stall;
        state_next = state;

        case (pcSrc)
            PCSRC_TARGET: next_pc = pcTarget;
            PCSRC_JALR:   next_pc = {aluResult[31:1], 1'b0};
            default:      next_pc = pcPlus4;   // PCSRC_PLUS4 and reserved
        endcase

        target_ok = is_aligned(next_pc);

        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (advance && !target_ok) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC         <= RESET_VECTOR;
            misaligned <= 1'b0;
            badAddr    <= '0;
            fetchCount <= '0;
        end else if (advance) begin
            if (target_ok) begin
                PC         <= next_pc;
                fetchCount <= fetchCount + COUNT_W'(1);
            end else begin
                // Trap: PC and counter keep their values, target is recorded.
                misaligned <= 1'b1;
                badAddr    <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed, table-driven bench for pc_fetch_unit. A main instance
// (RESET_VECTOR = 0x100, COUNT_W = 32) and a narrow-counter instance
// (COUNT_W = 4) share the same stimulus.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pcSrc;
    logic [31:0] pcTarget;
    logic [31:0] aluResult;
    logic        imemReady;

    logic [31:0] PC, pcPlus4, badAddr, fetchCount;
    logic        imemValid, misaligned;

    logic [31:0] pc_s, plus4_s, bad_s;
    logic        valid_s, mis_s;
    logic [3:0]  cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0100), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pcSrc(pcSrc),
        .pcTarget(pcTarget), .aluResult(aluResult), .imemReady(imemReady),
        .PC(PC), .pcPlus4(pcPlus4), .imemValid(imemValid),
        .misaligned(misaligned), .badAddr(badAddr), .fetchCount(fetchCount)
    );

    pc_fetch_unit #(.RESET_VECTOR(32'h0000_0100), .COUNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .pcSrc(pcSrc),
        .pcTarget(pcTarget), .aluResult(aluResult), .imemReady(imemReady),
        .PC(pc_s), .pcPlus4(plus4_s), .imemValid(valid_s),
        .misaligned(mis_s), .badAddr(bad_s), .fetchCount(cnt_s)
    );

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        valid;
        logic        mis;
        logic [31:0] bad;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic valid,
                           input logic mis, input logic [31:0] badv, input logic [31:0] cnt);
        chk({tag, ".PC"},         PC,                 pc);
        chk({tag, ".pcPlus4"},    pcPlus4,            pc + 32'd4);
        chk({tag, ".imemValid"},  {31'b0, imemValid}, {31'b0, valid});
        chk({tag, ".misaligned"}, {31'b0, misaligned},{31'b0, mis});
        chk({tag, ".badAddr"},    badAddr,            badv);
        chk({tag, ".fetchCount"}, fetchCount,         cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           stall src    pcTarget       aluResult      rdy  PC             pcPlus4        vld mis badAddr        cnt
        vecs[0]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_0100, 32'h0000_0104, 1'b1, 1'b0, 32'h0,         32'd0};
        vecs[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_0104, 32'h0000_0108, 1'b1, 1'b0, 32'h0,         32'd1};
        vecs[2]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_0108, 32'h0000_010C, 1'b1, 1'b0, 32'h0,         32'd2};
        vecs[3]  = '{1'b0, 2'b01, 32'h0000_2000, 32'h0,         1'b1, 32'h0000_2000, 32'h0000_2004, 1'b1, 1'b0, 32'h0,         32'd3};
        vecs[4]  = '{1'b0, 2'b10, 32'h0,         32'h0000_3001, 1'b1, 32'h0000_3000, 32'h0000_3004, 1'b1, 1'b0, 32'h0,         32'd4};
        vecs[5]  = '{1'b0, 2'b11, 32'h0000_5000, 32'h0,         1'b1, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        // stall beats a misaligned target and a ready memory
        vecs[6]  = '{1'b1, 2'b01, 32'h0000_0003, 32'h0,         1'b1, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        vecs[7]  = '{1'b1, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        vecs[8]  = '{1'b1, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        // memory not ready: request held
        vecs[9]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        vecs[10] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 32'h0000_3004, 32'h0000_3008, 1'b1, 1'b0, 32'h0,         32'd5};
        vecs[11] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_3008, 32'h0000_300C, 1'b1, 1'b0, 32'h0,         32'd6};
        // PC wrap through 0xFFFF_FFFC
        vecs[12] = '{1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 32'h0,         32'd7};
        vecs[13] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0, 32'h0,         32'd8};
        // misaligned jalr target traps
        vecs[14] = '{1'b0, 2'b10, 32'h0,         32'h0000_3002, 1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_3002, 32'd8};
        vecs[15] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_3002, 32'd8};

        reset = 1'b1; stall = 1'b0; pcSrc = 2'b00;
        pcTarget = '0; aluResult = '0; imemReady = 1'b1;
        repeat (2) step();
        chk_all("reset", 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'd0);
        reset = 1'b0;
        #1;
        chk("boot.imemValid", {31'b0, imemValid}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            stall     = vecs[i].stall;
            pcSrc     = vecs[i].src;
            pcTarget  = vecs[i].tgt;
            aluResult = vecs[i].alu;
            imemReady = vecs[i].ready;
            step();
            chk($sformatf("v%0d.PC", i),         PC,                  vecs[i].pc);
            chk($sformatf("v%0d.pcPlus4", i),    pcPlus4,             vecs[i].plus4);
            chk($sformatf("v%0d.imemValid", i),  {31'b0, imemValid},  {31'b0, vecs[i].valid});
            chk($sformatf("v%0d.misaligned", i), {31'b0, misaligned}, {31'b0, vecs[i].mis});
            chk($sformatf("v%0d.badAddr", i),    badAddr,             vecs[i].bad);
            chk($sformatf("v%0d.fetchCount", i), fetchCount,          vecs[i].cnt);
        end

        // Asynchronous reset mid-cycle while halted: clears before next edge.
        pcSrc = 2'b00; imemReady = 1'b1; stall = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk_all("halt_reset", 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk_all("reboot", 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'd0);
        step();
        chk_all("rerun", 32'h0000_0100, 1'b1, 1'b0, 32'h0, 32'd0);

        // 16 accepts: 4-bit counter wraps to 0.
        for (int k = 1; k <= 16; k++) step();
        chk_all("count16", 32'h0000_0140, 1'b1, 1'b0, 32'h0, 32'd16);
        chk("small.fetchCount", {28'b0, cnt_s}, 32'd0);
        chk("small.PC", pc_s, 32'h0000_0140);

        // Reset in the middle of a handshake that is not being accepted.
        imemReady = 1'b0;
        step();
        chk("hs_hold.PC", PC, 32'h0000_0140);
        chk("hs_hold.imemValid", {31'b0, imemValid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("hs_reset", 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'd0);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-cycle core: holds the architectural PC and selects the next PC from PC+4, the branch/jal target (output of the PC-target adder) or the jalr target (ALU result).
- Presents the current PC to instruction memory with a valid/ready handshake.
- Supports stall and traps on misaligned control-flow targets.
- Keeps a retired-fetch counter for bring-up and performance checks.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 32, width of the fetch counter fetchCount.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard/debug hold; blocks PC advance.
- pcSrc  input  2  next-PC select: 00 = PC+4, 01 = pcTarget, 10 = jalr target, 11 = reserved.
- pcTarget  input  32  branch/jal target (PC + immExt) from the target adder.
- aluResult  input  32  jalr target before bit-0 clear.
- imemReady  input  1  instruction memory accepts the current PC.
- PC  output  32  current program counter.
- pcPlus4  output  32  PC + 4, combinational, wraps mod 2^32.
- imemValid  output  1  PC is a valid fetch request.
- misaligned  output  1  sticky trap flag.
- badAddr  output  32  offending target captured at trap.
- fetchCount  output  COUNT_W  number of accepted fetches.

Behaviour:
- Reset (async assert, any state):
  - PC = RESET_VECTOR, state = BOOT.
  - imemValid = 0, misaligned = 0, badAddr = 0, fetchCount = 0.
  - Deassertion is taken synchronously at the next clk edge.
- States:
  - BOOT: imemValid = 0. Unconditionally moves to RUN on the next edge; PC is unchanged.
  - RUN: imemValid = 1.
  - HALT: imemValid = 0. Exited only by reset.
- Advance condition: advance = (state == RUN) && imemValid && imemReady && !stall.
  - stall has priority; with stall = 1, PC, counter and state hold regardless of imemReady or pcSrc.
- Next-PC select (evaluated only on advance):
  - 00: PC+4.
  - 01: pcTarget.
  - 10: {aluResult[31:1], 1'b0}.
  - 11: treated as PC+4.
- All additions are mod 2^32, so 0xFFFF_FFFC + 4 = 0x0000_0000. No overflow flag.
- Alignment check (on advance):
  - If selected next PC [1:0] != 2'b00, the PC holds its current value.
  - misaligned <= 1, badAddr <= selected target, state <= HALT, fetchCount is not incremented.
- Normal advance: PC <= next PC, fetchCount <= fetchCount + 1, wrapping at 2^COUNT_W.
- Latency: the new PC is visible one cycle after the accepting edge. pcPlus4 follows PC combinationally with zero latency.
- Handshake: while imemValid = 1 and imemReady = 0, PC is held stable and imemValid stays 1; a request is never withdrawn in RUN.
- Simultaneous stall and misaligned target: stall wins. No trap is taken until the fetch actually advances.
- Reset during HALT or mid-handshake clears everything immediately, with no waiting for imemReady.

Decomposition:
- Shared core package:
  - pcSrc encodings: PCSRC_PLUS4, PCSRC_TARGET, PCSRC_JALR, PCSRC_RSVD.
  - State encodings: BOOT, RUN, HALT.
  - Instruction-step constant 4.
- No sub-module. The next-PC mux and alignment check are a small combinational block inside this module.
- The target adder stays a separate existing instance upstream.

Test Plan:
- Reset release with RESET_VECTOR = 0x100, pcSrc = 00, imemReady = 1: imemValid = 0 in the first cycle, then PC goes 0x100, 0x104, 0x108; fetchCount = 2 after two accepts.
- pcSrc = 01, pcTarget = 0x2000 on an accepting edge: next cycle PC = 0x2000, pcPlus4 = 0x2004.
- pcSrc = 10, aluResult = 0x0000_3001: PC = 0x3000 and no trap. Then aluResult = 0x0000_3002: misaligned = 1, badAddr = 0x3002, PC unchanged, imemValid = 0, fetchCount unchanged.
- stall = 1 for 3 cycles with imemReady = 1, then imemReady = 0 for 2 cycles: PC, fetchCount and imemValid = 1 all held. Release both: a single advance occurs.
- PC = 0xFFFF_FFFC with pcSrc = 00: next PC = 0x0000_0000. Also check fetchCount wrap with COUNT_W = 4 after 16 accepts reads 0.
- Assert reset asynchronously mid-cycle while in HALT: outputs return to reset values before the next clk edge, then the BOOT→RUN sequence repeats.
